// File: rtl/pe_array_rs.sv
// Row-stationary K x K convolution engine over an IW x IW tile (stride 1, no padding).
// K x OW processing elements; each output column is emitted as one registered pulse.
module pe_array_rs #(
  parameter  int DW   = 8,
  parameter  int K    = 3,
  parameter  int IW   = 5,
  parameter  int ACCW = 20,
  localparam int OW   = IW - K + 1,
  localparam int CW   = (OW > 1) ? $clog2(OW) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic [IW*IW*DW-1:0]   ifmap_in_flat,
  input  logic [K*K*DW-1:0]     filter_in_flat,
  output logic                  busy,
  output logic                  out_valid,
  output logic [CW-1:0]         out_col,
  output logic [OW*ACCW-1:0]    out_data_flat,
  output logic                  done
);

  localparam int TW  = $clog2(K);
  localparam int XAW = $clog2(IW * IW);
  localparam int FAW = $clog2(K * K);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state;
  logic [TW-1:0]          t;
  logic [CW-1:0]          c;
  logic signed [DW-1:0]   x_r [IW*IW];
  logic signed [DW-1:0]   f_r [K*K];
  logic signed [ACCW-1:0] acc      [K][OW];
  logic signed [ACCW-1:0] acc_nxt  [K][OW];
  logic signed [ACCW-1:0] col_sum  [OW];
  logic signed [ACCW-1:0] out_data [OW];
  logic                   accept;
  logic                   last_tap;
  logic                   last_col;

  // Full-precision signed product, sign-extended into the accumulator width.
  function automatic logic signed [ACCW-1:0] mac_term(input logic signed [DW-1:0] a,
                                                      input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = (2*DW)'(a) * (2*DW)'(b);
    return ACCW'(p);
  endfunction

  assign accept   = en && start && (state == IDLE);
  assign last_tap = (t == TW'(K - 1));
  assign last_col = (c == CW'(OW - 1));

  // Stage p0: per-PE product for tap t, running accumulation and column reduction.
  always_comb begin
    for (int r = 0; r < OW; r++) begin
      col_sum[r] = '0;
      for (int i = 0; i < K; i++) begin
        acc_nxt[i][r] = acc[i][r]
                      + mac_term(f_r[FAW'(i * K + int'(t))],
                                 x_r[XAW'((r + i) * IW + int'(c) + int'(t))]);
        col_sum[r]    = col_sum[r] + acc_nxt[i][r];
      end
    end
  end

  // Operands are captured once per run so the buffers may change while we compute.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < IW * IW; k++) x_r[k] <= ifmap_in_flat[k*DW +: DW];
      for (int k = 0; k < K * K; k++)   f_r[k] <= filter_in_flat[k*DW +: DW];
    end
  end

  // Stage p1: control, accumulator update and registered column output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      out_col   <= '0;
      t         <= '0;
      c         <= '0;
      for (int r = 0; r < OW; r++) begin
        out_data[r] <= '0;
        for (int i = 0; i < K; i++) acc[i][r] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= RUN;
              busy  <= 1'b1;
              t     <= '0;
              c     <= '0;
              for (int r = 0; r < OW; r++)
                for (int i = 0; i < K; i++) acc[i][r] <= '0;
            end
          end
          RUN: begin
            if (last_tap) begin
              for (int r = 0; r < OW; r++) begin
                out_data[r] <= col_sum[r];
                for (int i = 0; i < K; i++) acc[i][r] <= '0;
              end
              out_col   <= c;
              out_valid <= 1'b1;
              t         <= '0;
              if (last_col) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
                c     <= '0;
              end else begin
                c <= c + 1'b1;
              end
            end else begin
              for (int r = 0; r < OW; r++)
                for (int i = 0; i < K; i++) acc[i][r] <= acc_nxt[i][r];
              t <= t + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar r = 0; r < OW; r++) begin : g_out
    assign out_data_flat[r*ACCW +: ACCW] = out_data[r];
  end

endmodule
